// File: rtl/rr_bus_mux.sv
// rtl/rr_bus_mux.sv - round-robin N-channel capture mux with a one-entry output register
//
// Purpose:
//   Picks one requesting channel per capture slot in round-robin order, registers
//   its data and index, and holds them until the sink accepts them. A new item
//   can be captured in the same cycle the held one is consumed (1 item/cycle).
//
// Optional feature (macro RR_BUS_MUX_LOCK_EN):
//   Adds input 'lock'. When lock=1 in a capture cycle, the captured channel keeps
//   top priority for the next slot instead of the pointer advancing past it.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset, highest priority
//   en         in   capture enable; low blocks new captures, never drops a held item
//   req        in   [NCH]        per-channel request
//   din        in   [NCH*WIDTH]  channel k data at [k*WIDTH +: WIDTH]
//   lock       in   hold priority on the captured channel (RR_BUS_MUX_LOCK_EN only)
//   gnt        out  [NCH]        one-hot pulse for the channel captured this cycle
//   dout       out  [WIDTH]      registered data of the captured channel
//   dout_idx   out  [SELW]       index of the channel held in dout
//   dout_valid out  dout/dout_idx hold an unconsumed item
//   dout_ready in   sink accepts dout this cycle when dout_valid is high

module rr_bus_mux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] din,
`ifdef RR_BUS_MUX_LOCK_EN
  input  logic                 lock,
`endif
  output logic [NCH-1:0]       gnt,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_idx,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Scan positions run up to 2*NCH-2 before wrapping, so one extra bit is needed.
  localparam logic [SELW:0]   NCH_W  = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_W = SELW'(NCH-1);

  state_t            r_state;
  logic [SELW-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_dout;
  logic [SELW-1:0]   r_idx;

  logic              w_found;
  logic [SELW-1:0]   w_sel;
  logic [SELW:0]     w_scan;
  logic              w_slot_open;
  logic              w_cap;
  logic [SELW-1:0]   w_ptr_next;
  logic [WIDTH-1:0]  w_data;
  logic [NCH-1:0]    w_onehot;

  // Rotating priority scan: first set req bit starting at r_ptr, wrapping at NCH.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_scan = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_scan >= NCH_W) begin
        w_scan = w_scan - NCH_W;
      end
      if (!w_found && req[w_scan[SELW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_scan[SELW-1:0];
      end
    end
  end

  // Constant-index selection keeps the data mux free of variable part-selects.
  always_comb begin
    w_data   = '0;
    w_onehot = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_sel == SELW'(k)) begin
        w_data      = din[k*WIDTH +: WIDTH];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // The output register is free when empty or being drained this cycle.
  assign w_slot_open = (r_state == S_IDLE) || dout_ready;
  // rst is folded in so gnt can never pulse during reset.
  assign w_cap       = !rst && en && w_found && w_slot_open;

  always_comb begin
    w_ptr_next = (w_sel == LAST_W) ? '0 : w_sel + SELW'(1);
`ifdef RR_BUS_MUX_LOCK_EN
    if (lock) begin
      w_ptr_next = w_sel;
    end
`endif
  end

  assign gnt = w_cap ? w_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_dout  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            r_state <= S_HOLD;
            r_dout  <= w_data;
            r_idx   <= w_sel;
            r_ptr   <= w_ptr_next;
          end
        end
        S_HOLD: begin
          if (w_cap) begin
            // Back-to-back: the held item leaves as the new one is loaded.
            r_dout <= w_data;
            r_idx  <= w_sel;
            r_ptr  <= w_ptr_next;
          end else if (dout_ready) begin
            // dout/dout_idx intentionally keep their last values when draining.
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_idx   = r_idx;
  assign dout_valid = (r_state == S_HOLD);

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_in_req  : assert property (@(posedge clk) (gnt & ~req) == '0);
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
                    (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout) && $stable(dout_idx)));

endmodule

// File: tb/tb_rr_bus_mux.sv
// tb/tb_rr_bus_mux.sv - table-driven and scoreboard bench for rr_bus_mux (WIDTH=8, NCH=4)

module tb_rr_bus_mux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  localparam logic [31:0] D_RR = 32'h13121110;
  localparam logic [31:0] D_A5 = 32'h00A50000;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NCH-1:0]   req;
  logic [NCH*WIDTH-1:0] din;
  logic             lock;
  logic [NCH-1:0]   gnt;
  logic [WIDTH-1:0] dout;
  logic [SELW-1:0]  dout_idx;
  logic             dout_valid;
  logic             dout_ready;

  always #5 clk = ~clk;

  rr_bus_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .din        (din),
`ifdef RR_BUS_MUX_LOCK_EN
    .lock       (lock),
`endif
    .gnt        (gnt),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  typedef struct {
    logic           rst;
    logic           en;
    logic [3:0]     req;
    logic [31:0]    din;
    logic           rdy;
    logic           lock;
    logic [3:0]     exp_gnt;
    logic           exp_valid;
    logic [7:0]     exp_dout;
    logic [1:0]     exp_idx;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
  } item_t;

  vec_t  vecs[$];
  vec_t  lvecs[$];
  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] q,
                              input logic [31:0] d, input logic rd, input logic lk,
                              input logic [3:0] g, input logic v, input logic [7:0] o,
                              input logic [1:0] x);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.din = d; t.rdy = rd; t.lock = lk;
    t.exp_gnt = g; t.exp_valid = v; t.exp_dout = o; t.exp_idx = x;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_item(input logic [3:0] g, input logic [31:0] d);
    item_t it;
    it.data = '0;
    it.idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (g[k]) begin
        it.data = d[k*8 +: 8];
        it.idx  = 2'(k);
      end
    end
    sb.push_back(it);
  endtask

  task automatic pop_check(input string name);
    item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: output item with empty scoreboard", name);
    end else begin
      checks--;
      it = sb.pop_front();
      chk({name, "_sb_dout"}, 32'(dout), 32'(it.data));
      chk({name, "_sb_idx"}, 32'(dout_idx), 32'(it.idx));
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    rst = v.rst; en = v.en; req = v.req; din = v.din; dout_ready = v.rdy; lock = v.lock;
    #3;
    chk({name, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    if (v.exp_gnt != 4'b0000) push_item(v.exp_gnt, v.din);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(dout_valid), 32'(v.exp_valid));
    chk({name, "_dout"}, 32'(dout), 32'(v.exp_dout));
    chk({name, "_idx"}, 32'(dout_idx), 32'(v.exp_idx));
    if (v.exp_gnt != 4'b0000) pop_check(name);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; din = '0; dout_ready = 1'b0; lock = 1'b0;

    //                rst en req      din   rdy lk  gnt      vld dout   idx
    // reset with active requests, then idle
    vecs.push_back(mk(1, 1, 4'b1111, D_RR, 0, 0, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(1, 1, 4'b0000, D_RR, 0, 0, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 1, 4'b0000, D_RR, 0, 0, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 1, 4'b0000, D_RR, 0, 0, 4'b0000, 0, 8'h00, 2'd0));
    // single request on ch2, then 3 stall cycles with req still present
    vecs.push_back(mk(0, 1, 4'b0100, D_A5, 0, 0, 4'b0100, 1, 8'hA5, 2'd2));
    vecs.push_back(mk(0, 1, 4'b0100, D_A5, 0, 0, 4'b0000, 1, 8'hA5, 2'd2));
    vecs.push_back(mk(0, 1, 4'b0100, D_A5, 0, 0, 4'b0000, 1, 8'hA5, 2'd2));
    vecs.push_back(mk(0, 1, 4'b0100, D_A5, 0, 0, 4'b0000, 1, 8'hA5, 2'd2));
    // drain with no request: valid falls, data kept; ptr now 3
    vecs.push_back(mk(0, 1, 4'b0000, D_A5, 1, 0, 4'b0000, 0, 8'hA5, 2'd2));
    // wrap and skip from ptr=3 with req=0011
    vecs.push_back(mk(0, 1, 4'b0011, D_RR, 1, 0, 4'b0001, 1, 8'h10, 2'd0));
    vecs.push_back(mk(0, 1, 4'b0011, D_RR, 1, 0, 4'b0010, 1, 8'h11, 2'd1));
    // en=0 in HOLD with ready: drains, no grant
    vecs.push_back(mk(0, 0, 4'b1111, D_RR, 1, 0, 4'b0000, 0, 8'h11, 2'd1));
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 0, 0, 4'b0100, 1, 8'h12, 2'd2));
    // reset while holding discards the item and clears ptr
    vecs.push_back(mk(1, 1, 4'b1111, D_RR, 0, 0, 4'b0000, 0, 8'h00, 2'd0));
    // full-throughput round robin from ch0
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0001, 1, 8'h10, 2'd0));
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0100, 1, 8'h12, 2'd2));
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b1000, 1, 8'h13, 2'd3));
    vecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0001, 1, 8'h10, 2'd0));
    // en=0 must not drop a held item while stalled
    vecs.push_back(mk(0, 0, 4'b1111, D_RR, 0, 0, 4'b0000, 1, 8'h10, 2'd0));
    vecs.push_back(mk(0, 0, 4'b1111, D_RR, 1, 0, 4'b0000, 0, 8'h10, 2'd0));
    // only ch3 requesting from ptr=1, then again back-to-back from ptr=0
    vecs.push_back(mk(0, 1, 4'b1000, D_RR, 1, 0, 4'b1000, 1, 8'h13, 2'd3));
    vecs.push_back(mk(0, 1, 4'b1000, D_RR, 1, 0, 4'b1000, 1, 8'h13, 2'd3));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef RR_BUS_MUX_LOCK_EN
    lvecs.push_back(mk(1, 1, 4'b1111, D_RR, 1, 0, 4'b0000, 0, 8'h00, 2'd0));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0001, 1, 8'h10, 2'd0));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 1, 4'b0010, 1, 8'h11, 2'd1));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 1, 4'b0010, 1, 8'h11, 2'd1));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0010, 1, 8'h11, 2'd1));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b0100, 1, 8'h12, 2'd2));
    lvecs.push_back(mk(0, 1, 4'b1111, D_RR, 1, 0, 4'b1000, 1, 8'h13, 2'd3));
    for (int i = 0; i < lvecs.size(); i++) begin
      apply(lvecs[i], $sformatf("lock%0d", i));
    end
`endif

    // Random traffic against a small round-robin reference model.
    begin
      logic [1:0] m_ptr;
      logic       m_valid;
      logic [3:0] m_gnt;
      logic       found;
      int         c;
      apply(mk(1, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 2'd0), "rnd_rst");
      m_ptr = 2'd0;
      m_valid = 1'b0;
      for (int n = 0; n < 80; n++) begin
        rst = 1'b0; lock = 1'b0;
        en = ($urandom_range(0, 3) != 0);
        req = 4'($urandom_range(0, 15));
        din = $urandom;
        dout_ready = ($urandom_range(0, 2) != 0);
        m_gnt = 4'b0000;
        found = 1'b0;
        if (en && (req != 4'b0000) && (!m_valid || dout_ready)) begin
          for (int i = 0; i < NCH; i++) begin
            c = (int'(m_ptr) + i) % NCH;
            if (!found && req[c]) begin
              found = 1'b1;
              m_gnt[c] = 1'b1;
              m_ptr = 2'((c + 1) % NCH);
            end
          end
        end
        #3;
        chk($sformatf("rnd%0d_gnt", n), 32'(gnt), 32'(m_gnt));
        if (found) push_item(m_gnt, din);
        if (found) m_valid = 1'b1;
        else if (dout_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_valid", n), 32'(dout_valid), 32'(m_valid));
        if (found) pop_check($sformatf("rnd%0d", n));
      end
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
